// File: rtl/rvfi_retire_tracker.sv
// rtl/rvfi_retire_tracker.sv - RVFI order assignment, retire counting and pass/fail latch
// Optional PC continuity checking is built when PC_CHAIN_CHECK_EN is defined.
module rvfi_retire_tracker #(
    parameter int                NRET         = 1,
    parameter int                ORDER_W      = 64,
    parameter int                ERR_W        = 16,
    parameter int                WDOG_CYCLES  = 4096,
    parameter logic [ERR_W-1:0]  TIMEOUT_CODE = 16'hFFFF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic [NRET-1:0]         rvfi_valid,
    input  logic [NRET*32-1:0]      rvfi_pc_rdata,
    input  logic [NRET*32-1:0]      rvfi_pc_wdata,
    input  logic [ERR_W-1:0]        errcode_in,
    input  logic                    done_in,
    output logic [NRET*ORDER_W-1:0] rvfi_order,
    output logic [ORDER_W-1:0]      retired,
    output logic                    pass,
    output logic                    fail,
    output logic [ERR_W-1:0]        fail_code,
    output logic [ORDER_W-1:0]      fail_order
);

    localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES + 1) : 1;

    typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_e;

    state_e             state_q, state_d;
    logic [ORDER_W-1:0] retired_q, retired_d;
    logic [ERR_W-1:0]   fail_code_q, fail_code_d;
    logic [ORDER_W-1:0] fail_order_q, fail_order_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic [ORDER_W-1:0] order_acc;
    logic               any_valid;
    logic               timeout;
    logic               pc_err;

    // Each channel takes the running count of valid channels below it.
    always_comb begin
        order_acc  = retired_q;
        rvfi_order = '0;
        for (int j = 0; j < NRET; j++) begin
            rvfi_order[j*ORDER_W +: ORDER_W] = order_acc;
            if (rvfi_valid[j]) order_acc = order_acc + ORDER_W'(1);
        end
    end

    assign any_valid = |rvfi_valid;
    assign timeout   = (WDOG_CYCLES != 0) && !any_valid &&
                       (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

`ifdef PC_CHAIN_CHECK_EN
    logic [31:0] last_pc_q, last_pc_d;
    logic        pc_seen_q, pc_seen_d;
    logic [31:0] pc_exp;
    logic        pc_seen;

    // Channels are walked in order so intra-cycle retirements chain too.
    always_comb begin
        pc_exp  = last_pc_q;
        pc_seen = pc_seen_q;
        pc_err  = 1'b0;
        for (int j = 0; j < NRET; j++) begin
            if (rvfi_valid[j]) begin
                if (pc_seen && (rvfi_pc_rdata[j*32 +: 32] != pc_exp)) pc_err = 1'b1;
                pc_exp  = rvfi_pc_wdata[j*32 +: 32];
                pc_seen = 1'b1;
            end
        end
        last_pc_d = last_pc_q;
        pc_seen_d = pc_seen_q;
        if (clear) begin
            last_pc_d = '0;
            pc_seen_d = 1'b0;
        end else if (state_q == ST_RUN) begin
            last_pc_d = pc_exp;
            pc_seen_d = pc_seen;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_pc_q <= '0;
            pc_seen_q <= 1'b0;
        end else begin
            last_pc_q <= last_pc_d;
            pc_seen_q <= pc_seen_d;
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^{rvfi_pc_rdata, rvfi_pc_wdata};
    assign pc_err    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        retired_d    = retired_q;
        wdog_d       = wdog_q;
        fail_code_d  = fail_code_q;
        fail_order_d = fail_order_q;
        if (clear) begin
            state_d      = ST_RUN;
            retired_d    = '0;
            wdog_d       = '0;
            fail_code_d  = '0;
            fail_order_d = '0;
        end else if (state_q == ST_RUN) begin
            retired_d = order_acc;
            if (any_valid || (WDOG_CYCLES == 0)) wdog_d = '0;
            else                                 wdog_d = wdog_q + WDOG_W'(1);
            if (errcode_in != '0) begin
                state_d      = ST_FAIL;
                fail_code_d  = errcode_in;
                fail_order_d = retired_q;
            end else if (pc_err) begin
                state_d      = ST_FAIL;
                fail_code_d  = ERR_W'(16'h0C0C);
                fail_order_d = retired_q;
            end else if (timeout) begin
                state_d      = ST_FAIL;
                fail_code_d  = TIMEOUT_CODE;
                fail_order_d = retired_q;
            end else if (done_in) begin
                state_d = ST_PASS;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            retired_q    <= '0;
            wdog_q       <= '0;
            fail_code_q  <= '0;
            fail_order_q <= '0;
        end else begin
            state_q      <= state_d;
            retired_q    <= retired_d;
            wdog_q       <= wdog_d;
            fail_code_q  <= fail_code_d;
            fail_order_q <= fail_order_d;
        end
    end

    assign retired    = retired_q;
    assign pass       = (state_q == ST_PASS);
    assign fail       = (state_q == ST_FAIL);
    assign fail_code  = fail_code_q;
    assign fail_order = fail_order_q;

endmodule
